// File: rtl/bram_chk_pkg.sv
// Shared types for the BRAM self-test: FSM states, pattern seed and pattern function.
// No logic or latency of its own. No backpressure.
package bram_chk_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_00A5;

  // Callers zero-extend the address and truncate the result to their data width.
  function automatic logic [31:0] expected(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/bram_pb_checker_if.sv
// Single-port BRAM bus: address/write strobe/write data out, read data back one cycle later.
// No latency of its own. No backpressure: the BRAM accepts one access every cycle.
interface bram_pb_checker_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/bram_chk_cmp.sv
// Read-back checker: registers the issued read address, compares the returned word one cycle later.
// Results land one cycle after the data returns. No backpressure: one compare per cycle.
module bram_chk_cmp
  import bram_chk_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 8,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rd_issue,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic              mismatch;

  assign mismatch = vld_q && (rdata != DATA_W'(expected(32'(addr_q), SEED)));

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q          <= 1'b0;
      addr_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      vld_q  <= rd_issue;
      addr_q <= rd_addr;
      if (clear) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + (ADDR_W+1)'(1);
        if (err_count == '0)
          first_err_addr <= addr_q;
      end
    end
  end

endmodule

// File: rtl/bram_pb_checker.sv
// Button-started BRAM write/read-back self-test; done 2*DEPTH+2 cycles after the start pulse.
// Starts are ignored while busy; optional BRAM_CHK_FAULT_INJ_EN adds inject_fault to corrupt address 3.
module bram_pb_checker
  import bram_chk_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 8,
  parameter int          DEPTH  = 256,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PB_down,
`ifdef BRAM_CHK_FAULT_INJ_EN
  input  logic               inject_fault,
`endif
  bram_pb_checker_if.master  bram,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W:0]    err_count,
  output logic [ADDR_W-1:0]  first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start, rd_issue;
  logic              inj_start, inj_run;

`ifdef BRAM_CHK_FAULT_INJ_EN
  logic inj_q;
  always_ff @(posedge clk) begin
    if (reset)      inj_q <= 1'b0;
    else if (start) inj_q <= inject_fault;
  end
  assign inj_start = inject_fault;
  assign inj_run   = inj_q;
`else
  assign inj_start = 1'b0;
  assign inj_run   = 1'b0;
`endif

  // Fault injection inverts the whole word written at address 3.
  function automatic logic [DATA_W-1:0] wr_pattern(input logic [ADDR_W-1:0] a, input logic inj);
    return DATA_W'(expected(32'(a), SEED)) ^ {DATA_W{inj && (a == ADDR_W'(3))}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    start    = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (PB_down) begin
          start   = 1'b1;
          state_d = WRITE;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = wr_pattern('0, inj_start);
        end
      end
      WRITE: begin
        if (addr_q == LAST) begin
          state_d = READ;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          we_d    = 1'b1;
          wdata_d = wr_pattern(addr_q + ADDR_W'(1), inj_run);
        end
      end
      READ: begin
        rd_issue = 1'b1;
        if (addr_q == LAST) state_d = DRAIN;
        else                addr_d  = addr_q + ADDR_W'(1);
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  bram_chk_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clear          (start),
    .rd_issue       (rd_issue),
    .rd_addr        (addr_q),
    .rdata          (bram.rdata),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  assign bram.addr  = addr_q;
  assign bram.we    = we_q;
  assign bram.wdata = wdata_q;

  assign busy = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_bram_pb_checker.sv
// Self-checking bench: BRAM model with read-side stuck-at faults, reference results per run.
module tb_bram_pb_checker;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam logic [7:0] SEED8 = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  logic PB_down;
`ifdef BRAM_CHK_FAULT_INJ_EN
  logic inject_fault;
`endif
  logic          busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  int vec = 0;
  int miscompares = 0;

  logic [DW-1:0] mem   [256];
  logic [DW-1:0] smask [256];
  logic [DW-1:0] sval  [256];

  bram_pb_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

  bram_pb_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .PB_down        (PB_down),
`ifdef BRAM_CHK_FAULT_INJ_EN
    .inject_fault   (inject_fault),
`endif
    .bram           (bif),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // BRAM: synchronous read, stuck-at bits applied on the read path only.
  always @(posedge clk) begin
    if (bif.we) mem[bif.addr] <= bif.wdata;
    bif.rdata <= (mem[bif.addr] & ~smask[bif.addr]) | (sval[bif.addr] & smask[bif.addr]);
  end

  function automatic logic [7:0] pat(input int a);
    logic [7:0] a8;
    a8 = 8'(a);
    return a8 ^ SEED8;
  endfunction

  function automatic logic [7:0] written(input int a, input bit inj);
    return pat(a) ^ ((inj && a == 3) ? 8'hFF : 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      smask[i] = '0;
      sval[i]  = '0;
    end
  endtask

  task automatic run_and_check(input string name, input bit inj, input int g1, input int g2);
    int cyc;
    int n_err;
    int first;
    logic [7:0] rd;
    int exp_addr;
    n_err = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd = (written(a, inj) & ~smask[a]) | (sval[a] & smask[a]);
      if (rd != pat(a)) begin
        if (n_err == 0) first = a;
        n_err++;
      end
    end
    @(negedge clk);
    PB_down = 1'b1;
`ifdef BRAM_CHK_FAULT_INJ_EN
    inject_fault = inj;
`endif
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    PB_down = 1'b0;
    while (cyc <= 60) begin
      exp_addr = (cyc <= DEPTH) ? cyc - 1 : (cyc <= 2*DEPTH) ? cyc - DEPTH - 1 : DEPTH - 1;
      chk({name, ":busy"}, busy, (cyc <= 2*DEPTH + 1));
      chk({name, ":we"}, bif.we, (cyc <= DEPTH));
      chk({name, ":addr"}, bif.addr, exp_addr);
      if (cyc <= DEPTH) chk({name, ":wdata"}, bif.wdata, written(cyc - 1, inj));
      if (cyc <= DEPTH + 1) chk({name, ":err_cleared"}, err_count, 0);
      chk({name, ":done"}, done, (cyc >= 2*DEPTH + 2));
      if (done) break;
      PB_down = (cyc == g1 || cyc == g2);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    PB_down = 1'b0;
    chk({name, ":done_cycle"}, cyc, 2*DEPTH + 2);
    chk({name, ":err_count"}, err_count, n_err);
    chk({name, ":first_err_addr"}, first_err_addr, first);
    chk({name, ":pass"}, pass, (n_err == 0));
    @(negedge clk);
    chk({name, ":done_held"}, done, 1);
    chk({name, ":we_idle"}, bif.we, 0);
    chk({name, ":addr_held"}, bif.addr, DEPTH - 1);
  endtask

  initial begin
    reset   = 1'b1;
    PB_down = 1'b0;
`ifdef BRAM_CHK_FAULT_INJ_EN
    inject_fault = 1'b0;
`endif
    clear_faults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:pass", pass, 0);
    chk("rst:err_count", err_count, 0);
    chk("rst:first_err_addr", first_err_addr, 0);
    chk("rst:we", bif.we, 0);
    chk("rst:addr", bif.addr, 0);
    chk("rst:wdata", bif.wdata, 0);
    reset = 1'b0;

    run_and_check("clean_glitch", 1'b0, 3, 20);

    smask[5] = 8'h01;
    sval[5]  = 8'h01;
    run_and_check("stuck_a5_b0", 1'b0, 0, 0);

    clear_faults();
    run_and_check("restart_from_done", 1'b0, 0, 0);

    // Reset in the middle of the write phase.
    @(negedge clk);
    PB_down = 1'b1;
    @(posedge clk);
    @(negedge clk);
    PB_down = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("midrst:busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst:we", bif.we, 0);
    chk("midrst:busy", busy, 0);
    chk("midrst:done", done, 0);
    chk("midrst:addr", bif.addr, 0);
    chk("midrst:err_count", err_count, 0);
    reset = 1'b0;
    run_and_check("after_midrst", 1'b0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int nf;
      int fa;
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        fa = $urandom_range(0, 31);
        smask[fa] = 8'(1 << $urandom_range(0, 7));
        sval[fa]  = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      end
      run_and_check("random", 1'b0, $urandom_range(1, 33), $urandom_range(1, 33));
    end
    clear_faults();

`ifdef BRAM_CHK_FAULT_INJ_EN
    run_and_check("inject_on", 1'b1, 0, 0);
    run_and_check("inject_off", 1'b0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
